// File: rtl/rns_poly_addsub_engine_if.sv
// Stream and control bundle for the RNS add/sub engine: control handshake, operand beats in, result beats out.
// The engine is connected through the slave modport and the driver through the master modport.
interface rns_poly_addsub_engine_if #(
    parameter int LANES      = 2,
    parameter int N_PRIMES   = 3,
    parameter int PRIME_BITS = 32
);
    localparam int W = LANES * N_PRIMES * PRIME_BITS;

    logic         start;
    logic [1:0]   mode;
    logic         busy;
    logic         done;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a1;
    logic [W-1:0] in_b1;
    logic [W-1:0] in_a2;
    logic [W-1:0] in_b2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_a;
    logic [W-1:0] out_b;
    logic         range_err;

    modport master (
        output start, mode, in_valid, in_a1, in_b1, in_a2, in_b2, out_ready,
        input  busy, done, in_ready, out_valid, out_a, out_b, range_err
    );

    modport slave (
        input  start, mode, in_valid, in_a1, in_b1, in_a2, in_b2, out_ready,
        output busy, done, in_ready, out_valid, out_a, out_b, range_err
    );
endinterface

// File: rtl/rns_poly_addsub_engine.sv
// Streaming RNS ciphertext add/sub/negate unit with a single output register stage.
// Optional input range check is enabled by defining RNS_ADDSUB_RANGE_CHECK_EN.
//
// state   | meaning
// S_IDLE  | waiting for start; mode latched and beat counter cleared on start
// S_RUN   | accepting operand beats until N_SLOTS/LANES have been taken
// S_DRAIN | last result beat held until downstream takes it
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module rns_poly_addsub_engine #(
    parameter int N_SLOTS    = 8,
    parameter int N_PRIMES   = 3,
    parameter int PRIME_BITS = 32,
    parameter int LANES      = 2,
    parameter logic [N_PRIMES*PRIME_BITS-1:0] Q_MODULI =
        {32'd65521, 32'd2147483647, 32'd4294967291}
) (
    input logic                        clk,
    input logic                        reset,
    rns_poly_addsub_engine_if.slave    bus
);
    localparam int BEATS = N_SLOTS / LANES;
    localparam int CW    = $clog2(BEATS + 1);
    localparam int W     = LANES * N_PRIMES * PRIME_BITS;
    localparam int PB    = PRIME_BITS;

    localparam logic [1:0] MODE_CT_CT_ADD = 2'd0;
    localparam logic [1:0] MODE_CT_PT_ADD = 2'd1;
    localparam logic [1:0] MODE_CT_CT_SUB = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    mode_q;
    logic [CW-1:0] cnt;
    logic          out_valid_q;
    logic [W-1:0]  out_a_q, out_b_q;
    logic [W-1:0]  res_a, res_b;
    logic          busy_c, done_c, in_ready_c;
    logic          accept, start_acc;
    logic [PB-1:0] q, a1, b1, a2, b2;

    function automatic logic [PB-1:0] mod_add(input logic [PB-1:0] a, b, m);
        logic [PB:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[PB-1:0];
    endfunction

    function automatic logic [PB-1:0] mod_sub(input logic [PB-1:0] a, b, m);
        return (a < b) ? (a - b + m) : (a - b);
    endfunction

    function automatic logic [PB-1:0] mod_neg(input logic [PB-1:0] a, m);
        return (a == '0) ? '0 : (m - a);
    endfunction

    assign accept    = bus.in_valid & in_ready_c;
    assign start_acc = (state == S_IDLE) & bus.start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RUN;
            S_RUN:   if (accept && cnt == CW'(BEATS - 1)) state_nxt = S_DRAIN;
            S_DRAIN: if (out_valid_q && bus.out_ready) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_c     = (state != S_IDLE);
        done_c     = (state == S_DONE);
        in_ready_c = (state == S_RUN) && (cnt < CW'(BEATS)) && (!out_valid_q || bus.out_ready);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q      <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
        end else begin
            if (start_acc) begin
                mode_q <= bus.mode;
                cnt    <= '0;
            end else if (accept) begin
                cnt <= cnt + CW'(1);
            end
            if (accept) begin
                out_valid_q <= 1'b1;
                out_a_q     <= res_a;
                out_b_q     <= res_b;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        res_a = '0;
        res_b = '0;
        q = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int p = 0; p < N_PRIMES; p++) begin
                q  = Q_MODULI[p*PB +: PB];
                a1 = bus.in_a1[(l*N_PRIMES+p)*PB +: PB];
                b1 = bus.in_b1[(l*N_PRIMES+p)*PB +: PB];
                a2 = bus.in_a2[(l*N_PRIMES+p)*PB +: PB];
                b2 = bus.in_b2[(l*N_PRIMES+p)*PB +: PB];
                case (mode_q)
                    MODE_CT_CT_ADD: begin
                        res_a[(l*N_PRIMES+p)*PB +: PB] = mod_add(a1, a2, q);
                        res_b[(l*N_PRIMES+p)*PB +: PB] = mod_add(b1, b2, q);
                    end
                    MODE_CT_PT_ADD: begin
                        res_a[(l*N_PRIMES+p)*PB +: PB] = a1;
                        res_b[(l*N_PRIMES+p)*PB +: PB] = mod_add(b1, b2, q);
                    end
                    MODE_CT_CT_SUB: begin
                        res_a[(l*N_PRIMES+p)*PB +: PB] = mod_sub(a1, a2, q);
                        res_b[(l*N_PRIMES+p)*PB +: PB] = mod_sub(b1, b2, q);
                    end
                    default: begin
                        res_a[(l*N_PRIMES+p)*PB +: PB] = mod_neg(a1, q);
                        res_b[(l*N_PRIMES+p)*PB +: PB] = mod_neg(b1, q);
                    end
                endcase
            end
        end
    end

`ifdef RNS_ADDSUB_RANGE_CHECK_EN
    logic range_hit;
    logic range_err_q;

    // Only operands the latched mode actually consumes are range checked.
    always_comb begin
        range_hit = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            for (int p = 0; p < N_PRIMES; p++) begin
                if (bus.in_a1[(l*N_PRIMES+p)*PB +: PB] >= Q_MODULI[p*PB +: PB]) range_hit = 1'b1;
                if (bus.in_b1[(l*N_PRIMES+p)*PB +: PB] >= Q_MODULI[p*PB +: PB]) range_hit = 1'b1;
                if ((mode_q == MODE_CT_CT_ADD || mode_q == MODE_CT_CT_SUB) &&
                    bus.in_a2[(l*N_PRIMES+p)*PB +: PB] >= Q_MODULI[p*PB +: PB]) range_hit = 1'b1;
                if ((mode_q != 2'd3) &&
                    bus.in_b2[(l*N_PRIMES+p)*PB +: PB] >= Q_MODULI[p*PB +: PB]) range_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  range_err_q <= 1'b0;
        else if (start_acc)          range_err_q <= 1'b0;
        else if (accept && range_hit) range_err_q <= 1'b1;
    end

    assign bus.range_err = range_err_q;
`else
    assign bus.range_err = 1'b0;
`endif

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
endmodule

// File: tb/tb_rns_poly_addsub_engine.sv
// Scoreboard bench for rns_poly_addsub_engine: directed beats push hand-computed results, a monitor pops and compares.
// Range-error expectations follow RNS_ADDSUB_RANGE_CHECK_EN.
module tb_rns_poly_addsub_engine;
    localparam int LANES = 2, N_PRIMES = 3, PB = 32, N_SLOTS = 8, BEATS = 4;
    localparam int W = LANES * N_PRIMES * PB;
    localparam logic [N_PRIMES*PB-1:0] QM = {32'd65521, 32'd2147483647, 32'd4294967291};

`ifdef RNS_ADDSUB_RANGE_CHECK_EN
    localparam logic EXP_RE = 1'b1;
`else
    localparam logic EXP_RE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rns_poly_addsub_engine_if #(.LANES(LANES), .N_PRIMES(N_PRIMES), .PRIME_BITS(PB)) bus();

    rns_poly_addsub_engine #(
        .N_SLOTS(N_SLOTS), .N_PRIMES(N_PRIMES), .PRIME_BITS(PB), .LANES(LANES), .Q_MODULI(QM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_pop_cyc = -10;
    logic [W-1:0] held_a, held_b;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] vc(input logic [PB-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < LANES * N_PRIMES; i++) r[i*PB +: PB] = v;
        return r;
    endfunction

    // Every residue set to q_p - k for its own prime.
    function automatic logic [W-1:0] vq(input logic [PB-1:0] k);
        logic [W-1:0] r;
        logic [N_PRIMES*PB-1:0] qm;
        qm = QM;
        for (int l = 0; l < LANES; l++)
            for (int p = 0; p < N_PRIMES; p++)
                r[(l*N_PRIMES+p)*PB +: PB] = qm[p*PB +: PB] - k;
        return r;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual=%0h required=none", bus.out_a);
            end else begin
                e = exp_q.pop_front();
                chk("out_a", bus.out_a, e.a);
                chk("out_b", bus.out_b, e.b);
                last_pop_cyc = cyc;
            end
        end
        if (reset && bus.done) begin
            chk("done_latency", cyc, last_pop_cyc + 1);
            chk("done_queue_empty", exp_q.size(), 0);
        end
    end

    task automatic start_op(input logic [1:0] m);
        bus.start = 1'b1;
        bus.mode  = m;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.mode  = 2'd0;
        chk("busy_after_start", bus.busy, 1'b1);
    endtask

    task automatic send_beat(input logic [W-1:0] a1, b1, a2, b2, ea, eb);
        bit ok = 0;
        bus.in_a1 = a1; bus.in_b1 = b1; bus.in_a2 = a2; bus.in_b2 = b2;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back('{a: ea, b: eb});
                ok = 1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL beat_accept_timeout actual=no_ready required=ready");
        end
    endtask

    task automatic wait_done();
        bit seen = 0;
        chk("no_extra_in_ready", bus.in_ready, 1'b0);
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=0 required=1");
        end
        @(negedge clk);
        chk("done_one_pulse", bus.done, 1'b0);
        chk("busy_after_done", bus.busy, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic run_const(input logic [1:0] m, input logic [W-1:0] a1, b1, a2, b2, ea, eb);
        start_op(m);
        for (int k = 0; k < BEATS; k++) send_beat(a1, b1, a2, b2, ea, eb);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 0; bus.mode = 0; bus.in_valid = 0; bus.out_ready = 1;
        bus.in_a1 = '0; bus.in_b1 = '0; bus.in_a2 = '0; bus.in_b2 = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_range_err", bus.range_err, 1'b0);
        chk("rst_out_a", bus.out_a, '0);
        chk("rst_out_b", bus.out_b, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_const(2'd0, vc(5), vc(10), vc(7), vc(3), vc(12), vc(13));
        run_const(2'd1, vc(5), vc(10), vc(999), vc(4), vc(5), vc(14));
        run_const(2'd0, vq(1), vq(1), vc(2), vc(1), vc(1), vc(0));
        run_const(2'd2, vc(3), vc(7), vc(7), vc(3), vq(4), vc(4));

        start_op(2'd3);
        send_beat(vc(0), vc(1), vc(123), vc(123), vc(0), vq(1));
        for (int k = 1; k < BEATS; k++) send_beat(vc(1), vc(0), vc(123), vc(123), vq(1), vc(0));
        wait_done();

        // Backpressure: stall the output for three cycles while the stream is mid-flight.
        start_op(2'd0);
        fork
            for (int k = 0; k < BEATS; k++)
                send_beat(vc(10 + k), vc(20 + k), vc(1), vc(2), vc(11 + k), vc(22 + k));
            begin
                for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
                @(posedge clk); #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                held_a = bus.out_a;
                held_b = bus.out_b;
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("bp_out_valid", bus.out_valid, 1'b1);
                    chk("bp_in_ready", bus.in_ready, 1'b0);
                    chk("bp_hold_a", bus.out_a, held_a);
                    chk("bp_hold_b", bus.out_b, held_b);
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_done();

        start_op(2'd0);
        send_beat(vc(8), vc(9), vc(3), vc(4), vc(11), vc(13));
        bus.start = 1'b1;
        bus.mode  = 2'd2;
        send_beat(vc(8), vc(9), vc(3), vc(4), vc(11), vc(13));
        bus.start = 1'b0;
        bus.mode  = 2'd0;
        send_beat(vc(8), vc(9), vc(3), vc(4), vc(11), vc(13));
        send_beat(vc(8), vc(9), vc(3), vc(4), vc(11), vc(13));
        wait_done();

        start_op(2'd0);
        send_beat(vc(1), vc(1), vc(1), vc(1), vc(2), vc(2));
        send_beat(vc(1), vc(1), vc(1), vc(1), vc(2), vc(2));
        bus.in_valid = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_in_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_const(2'd0, vc(2), vc(6), vc(3), vc(5), vc(5), vc(11));

        start_op(2'd0);
        send_beat(vq(0), vc(1), vc(0), vc(1), vc(0), vc(2));
        chk("range_err_set", bus.range_err, EXP_RE);
        for (int k = 1; k < BEATS; k++) send_beat(vc(4), vc(1), vc(1), vc(1), vc(5), vc(2));
        wait_done();
        chk("range_err_held", bus.range_err, EXP_RE);
        start_op(2'd0);
        chk("range_err_clear_on_start", bus.range_err, 1'b0);
        for (int k = 0; k < BEATS; k++) send_beat(vc(4), vc(1), vc(1), vc(1), vc(5), vc(2));
        wait_done();
        chk("range_err_clean_op", bus.range_err, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
